mem_line_responder: RTL
=======================

// Module: mem_line_responder
// PURPOSE
// - Memory-side responder for the cache<->memory line bus (bus 2). Serves C2_READ_LINE and C2_WRITE_LINE from the cache.
// - Holds the backing store and models fixed memory latency. Sits between the cache's bus-2 initiator and the top-level bus wiring.
// - Bus 2 uses split in/out/output-enable signals. The top level resolves these onto the shared inout wires.
// PARAMETERS
// ADDR2_W     14   line-address width ({tag,set}); memory = 2**ADDR2_W lines
// DATA_W      16   D2 width; beat = 2 bytes
// LINE_BYTES  16   bytes per line; LINE_BEATS = LINE_BYTES*8/DATA_W = 8
// MEM_DELAY   100  cycles from command-sample edge to first C2_RESPONSE cycle
// PORTS
// CLK      in   1        clock; all state changes on posedge
// RESET_N  in   1        asynchronous, active-low reset
// C2_IN    in   2        bus-2 command from cache: 0 NOP, 1 RESPONSE, 2 READ_LINE, 3 WRITE_LINE
// A2_IN    in   ADDR2_W  line address, valid in command cycle
// D2_IN    in   DATA_W   write data beat; [7:0] = byte 2k, [15:8] = byte 2k+1
// C2_OUT   out  2        command driven by this block (NOP or RESPONSE)
// C2_OE    out  1        this block drives C2
// D2_OUT   out  DATA_W   read data beat, same byte order as D2_IN
// D2_OE    out  1        this block drives D2
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, C2_OUT=0, C2_OE=0, D2_OUT=0, D2_OE=0, counters=0.
// - Reset leaves memory array contents unchanged. Memory is not reset.
// - Cycle t0 = cycle in which IDLE samples C2_IN=READ_LINE or WRITE_LINE. A2_IN is latched at t0.
// - IDLE: NOP, RESPONSE and all other codes are ignored. While not IDLE, C2_IN/A2_IN are ignored; the bus is owned.
// - WRITE_LINE: beat k (k=0..LINE_BEATS-1) is sampled from D2_IN at edge t0+k (state WR_RECV).
// - WRITE_LINE: bytes go to line A2 at offsets 2k and 2k+1. C2_IN value during beats 1..7 is don't-care.
// - WRITE_LINE: then state WAIT. C2_OUT=RESPONSE, C2_OE=1 for exactly cycle t0+MEM_DELAY, D2_OE=0. Then IDLE, outputs released.
// - READ_LINE: state WAIT until cycle t0+MEM_DELAY, then RD_SEND for LINE_BEATS cycles.
// - RD_SEND: C2_OUT=RESPONSE, C2_OE=1, D2_OE=1 on every beat cycle. D2_OUT beat k = {byte 2k+1, byte 2k} in cycle t0+MEM_DELAY+k.
// - RD_SEND: after beat 7, back to IDLE. C2_OE, D2_OE, C2_OUT and D2_OUT return to 0 in the next cycle.
// - New command acceptance: earliest in the cycle after the last RESPONSE cycle. Back-to-back transactions need no gap cycle.
// - Delay counter width = $clog2(MEM_DELAY+1). No wrap: the counter is loaded at t0 and counts down to terminal value.
// - Elaboration $error if MEM_DELAY < LINE_BEATS+1 (write beats must finish before RESPONSE).
// - Elaboration $error if DATA_W != 16 or LINE_BYTES % 2 != 0.
// - Read of a line never written returns the memory initial value (see CONFIGURATION).
// - Write then read of the same line returns the written data. No read-during-write hazard: transactions are serialised.
// - RESET_N asserted mid-transaction aborts it. Partial write beats already stored stay stored; the rest of the line is untouched.
// - After reset, outputs are released immediately (async). The next command is accepted in the first cycle after release.
// CONFIGURATION
// - MEM_LINE_RESPONDER_STATS_EN defined: adds out ports RD_CNT[31:0] and WR_CNT[31:0].
//   - RD_CNT increments at the last read beat; WR_CNT increments in the write RESPONSE cycle.
//   - Both saturate at 32'hFFFF_FFFF and are cleared by RESET_N. Transactions aborted by reset are not counted.
// - MEM_LINE_RESPONDER_STATS_EN undefined: ports and counters absent; bus behaviour identical.
// - Memory initial contents: byte i = i[7:0] (deterministic, so benches can predict unwritten data).
// TESTING
// - Reset: RESET_N=0 for 3 cycles -> C2_OE=0, D2_OE=0, C2_OUT=0, D2_OUT=0 while reset is asserted and the cycle after.
// - Read unwritten: READ_LINE A2=5 at t0 -> first RESPONSE at exactly t0+100.
//   Beat 0 D2_OUT=16'h5150, beat 7 = 16'h5F5E (bytes 0x50..0x5F). Outputs released at t0+108.
// - Write/readback: WRITE_LINE A2=0x3FFF, beats 16'h0100..16'h0F0E -> single RESPONSE cycle at t0+100.
//   Immediately after, READ_LINE A2=0x3FFF (next cycle) -> same 8 beats returned in order.
// - Busy ignore: C2_IN=READ_LINE A2=7 injected at t0+20 during a write -> no effect.
//   Exactly one RESPONSE cycle at t0+100; line 7 unchanged.
// - Reset mid-read: RESET_N low at t0+103 (beat 3) -> D2_OE/C2_OE drop asynchronously.
//   READ_LINE A2=1 after release is served normally with latency 100.
// - Stats (MEM_LINE_RESPONDER_STATS_EN): 2 reads + 1 write + 1 read aborted by reset (then no reset) -> RD_CNT=2, WR_CNT=1.

Source files
------------

// File: rtl/mem_line_responder.sv
// mem_line_responder
//   Memory-side responder on the cache<->memory line bus (bus 2). Accepts
//   READ_LINE / WRITE_LINE from the cache, holds the backing store and models
//   a fixed memory latency before answering with RESPONSE cycles.
//
// Ports
//   CLK, RESET_N        clock (posedge), asynchronous active-low reset
//   C2_IN, A2_IN, D2_IN command / line address / write beat from the cache
//   C2_OUT, C2_OE       command driven by this block (NOP or RESPONSE) + enable
//   D2_OUT, D2_OE       read data beat + enable
//   RD_CNT, WR_CNT      completed read / write counters (only with
//                       MEM_LINE_RESPONDER_STATS_EN defined)
//
// Optional feature macro: MEM_LINE_RESPONDER_STATS_EN
module mem_line_responder #(
  parameter int ADDR2_W    = 14,
  parameter int DATA_W     = 16,
  parameter int LINE_BYTES = 16,
  parameter int MEM_DELAY  = 100
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [1:0]         C2_IN,
  input  logic [ADDR2_W-1:0] A2_IN,
  input  logic [DATA_W-1:0]  D2_IN,
  output logic [1:0]         C2_OUT,
  output logic               C2_OE,
  output logic [DATA_W-1:0]  D2_OUT,
  output logic               D2_OE
`ifdef MEM_LINE_RESPONDER_STATS_EN
  ,
  output logic [31:0]        RD_CNT,
  output logic [31:0]        WR_CNT
`endif
);

  localparam int LINE_BEATS = LINE_BYTES * 8 / DATA_W;
  localparam int BEAT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int DLY_W      = $clog2(MEM_DELAY + 1);
  localparam int MADDR_W    = ADDR2_W + BEAT_W;

  localparam logic [1:0] C2_NOP   = 2'd0;
  localparam logic [1:0] C2_RESP  = 2'd1;
  localparam logic [1:0] C2_READ  = 2'd2;
  localparam logic [1:0] C2_WRITE = 2'd3;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  // Counter is loaded at the command edge and the state moves on the edge
  // where it reads zero; that edge opens cycle t0+MEM_DELAY.
  localparam logic [DLY_W-1:0]  DLY_LOAD  = DLY_W'(MEM_DELAY - 2);

  if (MEM_DELAY < LINE_BEATS + 1) begin : g_err_delay
    $error("mem_line_responder: MEM_DELAY must be >= LINE_BEATS+1");
  end
  if (DATA_W != 16 || (LINE_BYTES % 2) != 0) begin : g_err_width
    $error("mem_line_responder: DATA_W must be 16 and LINE_BYTES even");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_RECV = 3'd1,
    S_WAIT    = 3'd2,
    S_WR_RESP = 3'd3,
    S_RD_SEND = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR2_W-1:0]  addr_q, addr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic                is_wr_q, is_wr_d;

  logic                mem_we;
  logic [ADDR2_W-1:0]  mem_wline;
  logic [BEAT_W-1:0]   mem_wbeat;
  logic [DATA_W-1:0]   mem_rdata;

  // Storage holds data XOR the power-up pattern, so a zero-initialised
  // array reads back as byte i = i[7:0] without any reset of the array.
  logic [DATA_W-1:0]   mem [0:(2**MADDR_W)-1];

  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR2_W-1:0] a,
                                                  input logic [BEAT_W-1:0]  bt);
    logic [7:0] lo;
    lo = 8'(32'(a) * 32'(LINE_BYTES) + 32'(bt) * 32'd2);
    return {lo + 8'd1, lo};  // lo is even, so +1 never carries
  endfunction

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      dly_q   <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      dly_q   <= dly_d;
      is_wr_q <= is_wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    dly_d     = dly_q;
    is_wr_d   = is_wr_q;
    mem_we    = 1'b0;
    mem_wline = addr_q;
    mem_wbeat = beat_q;
    // latency runs from the command edge, overlapping the write beats
    if ((state_q == S_WR_RECV || state_q == S_WAIT) && dly_q != '0)
      dly_d = dly_q - 1'b1;
    case (state_q)
      S_IDLE: begin
        if (C2_IN == C2_READ || C2_IN == C2_WRITE) begin
          addr_d  = A2_IN;
          dly_d   = DLY_LOAD;
          is_wr_d = (C2_IN == C2_WRITE);
          beat_d  = '0;
          state_d = S_WAIT;
          if (C2_IN == C2_WRITE) begin
            // beat 0 travels with the command
            mem_we    = RESET_N;
            mem_wline = A2_IN;
            mem_wbeat = '0;
            if (LINE_BEATS > 1) begin
              beat_d  = BEAT_W'(1);
              state_d = S_WR_RECV;
            end
          end
        end
      end
      S_WR_RECV: begin
        mem_we = RESET_N;
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dly_q == '0) begin
          beat_d  = '0;
          state_d = is_wr_q ? S_WR_RESP : S_RD_SEND;
        end
      end
      S_WR_RESP: state_d = S_IDLE;
      S_RD_SEND: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (mem_we)
      mem[{mem_wline, mem_wbeat}] <= D2_IN ^ init_word(mem_wline, mem_wbeat);
  end

  assign mem_rdata = mem[{addr_q, beat_q}] ^ init_word(addr_q, beat_q);

  // Outputs decode straight from state so reset releases the bus at once.
  assign C2_OE  = (state_q == S_WR_RESP) || (state_q == S_RD_SEND);
  assign C2_OUT = C2_OE ? C2_RESP : C2_NOP;
  assign D2_OE  = (state_q == S_RD_SEND);
  assign D2_OUT = D2_OE ? mem_rdata : '0;

`ifdef MEM_LINE_RESPONDER_STATS_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RD_CNT <= '0;
      WR_CNT <= '0;
    end else begin
      if (state_q == S_RD_SEND && beat_q == LAST_BEAT && RD_CNT != 32'hFFFF_FFFF)
        RD_CNT <= RD_CNT + 32'd1;
      if (state_q == S_WR_RESP && WR_CNT != 32'hFFFF_FFFF)
        WR_CNT <= WR_CNT + 32'd1;
    end
  end
`endif

endmodule
